pa_fifo_sched: RTL

PA_FIFO_SCHED -- requirements
Module: pa_fifo_sched

---
 rtl/pa_fifo_sched.sv | 116 +++++++++++
 1 files changed

// File: rtl/pa_fifo_sched.sv
// Arbitrates four word requesters into datapath FIFO0 via an A0 copy and an F0 load strobe.
// Round-robin or fixed priority, one word per three cycles at best, all outputs registered.
module pa_fifo_sched #(
    parameter bit PRIO_FIXED = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [3:0] req_i,
    input  logic [7:0] data0_i,
    input  logic [7:0] data1_i,
    input  logic [7:0] data2_i,
    input  logic [7:0] data3_i,
    output logic [3:0] ack_o,
    output logic [2:0] dp_cs_addr_o,
    output logic [7:0] dp_pi_o,
    output logic       dp_f0_load_o,
    input  logic       dp_f0_full_i,
    output logic [1:0] grant_id_o,
    output logic       busy_o,
    output logic [7:0] words_loaded_o
);

    typedef enum logic [1:0] {StIdle, StCopy, StWait, StLoad} state_e;

    state_e     state_q;
    logic [3:0] ack_q;
    logic [2:0] cs_q;
    logic [7:0] pi_q;
    logic       load_q;
    logic [1:0] grant_q;
    logic       busy_q;
    logic [7:0] words_q;
    logic [1:0] rr_ptr_q;

    logic [1:0] win_id;
    logic [1:0] idx;
    logic [7:0] win_data;

    // Scan from the highest offset down so the lowest offset from the start point wins.
    always_comb begin
        win_id = 2'd0;
        idx    = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            idx = PRIO_FIXED ? 2'(k) : rr_ptr_q + 2'(k);
            if (req_i[idx]) begin
                win_id = idx;
            end
        end
    end

    always_comb begin
        win_data = data0_i;
        case (win_id)
            2'd0: win_data = data0_i;
            2'd1: win_data = data1_i;
            2'd2: win_data = data2_i;
            2'd3: win_data = data3_i;
            default: win_data = data0_i;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            ack_q    <= 4'b0000;
            cs_q     <= 3'b000;
            pi_q     <= 8'h00;
            load_q   <= 1'b0;
            grant_q  <= 2'd0;
            busy_q   <= 1'b0;
            words_q  <= 8'h00;
            rr_ptr_q <= 2'd0;
        end else begin
            ack_q  <= 4'b0000;
            load_q <= 1'b0;
            cs_q   <= 3'b000;
            unique case (state_q)
                StIdle: begin
                    if ((req_i != 4'b0000) && !dp_f0_full_i) begin
                        state_q  <= StCopy;
                        cs_q     <= 3'b001;
                        pi_q     <= win_data;
                        grant_q  <= win_id;
                        rr_ptr_q <= win_id + 2'd1;
                        busy_q   <= 1'b1;
                    end
                end
                // COPY and WAIT differ only in that COPY has already loaded A0.
                StCopy, StWait: begin
                    if (!dp_f0_full_i) begin
                        state_q <= StLoad;
                        load_q  <= 1'b1;
                        ack_q   <= 4'b0001 << grant_q;
                        words_q <= words_q + 8'd1;
                    end else begin
                        state_q <= StWait;
                    end
                end
                StLoad: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign ack_o          = ack_q;
    assign dp_cs_addr_o   = cs_q;
    assign dp_pi_o        = pi_q;
    assign dp_f0_load_o   = load_q;
    assign grant_id_o     = grant_q;
    assign busy_o         = busy_q;
    assign words_loaded_o = words_q;

endmodule
